// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Also carries a word-level difference function used as a reference.
package serial_sub_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [DEF_WIDTH-1:0] ref_diff(input logic [DEF_WIDTH-1:0] x,
                                                    input logic [DEF_WIDTH-1:0] y);
    return x - y;
  endfunction

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit full subtractor: diff = x - y - bin, with borrow out.
module serial_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor d = a - b, LSB first, one bit per clock, with
// parallel load on start and a one-cycle done pulse carrying the result.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rd;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             cell_diff;
  logic             cell_bout;
  logic             last_bit;
  logic [WIDTH-1:0] rd_next;

  serial_sub_cell u_cell (
    .x    (ra[0]),
    .y    (rb[0]),
    .bin  (borrow),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign rd_next  = {cell_diff, rd[WIDTH-1:1]};
  assign busy     = (state == SHIFT);
  assign done     = (state == DONE);

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ra     <= '0;
      rb     <= '0;
      rd     <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra     <= a;
            rb     <= b;
            rd     <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          ra     <= ra >> 1;
          rb     <= rb >> 1;
          rd     <= rd_next;
          borrow <= cell_bout;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            // On the last bit ra[0]/rb[0] hold the captured operand MSBs.
            d    <= rd_next;
            bout <= cell_bout;
            ovf  <= (ra[0] ^ rb[0]) & (cell_diff ^ ra[0]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed cases, random operations,
// back-to-back starts, reset abort and an exhaustive operand sweep.
module tb_serial_sub;
  import serial_sub_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns {bout, ovf, d} from word-level arithmetic.
  function automatic logic [5:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r  = sx - sy;
    return {(x < y), (r > 7 || r < -8), ref_diff(x, y)};
  endfunction

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    int n, nb;
    logic [5:0] e;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    n = 0; nb = 0;
    while (!done && n < 20) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    e = model(x, y);
    check({tag, "_latency"}, n, W);
    check({tag, "_busy_cycles"}, nb, W);
    check({tag, "_d"}, d, e[3:0]);
    check({tag, "_bout"}, bout, e[5]);
    check({tag, "_ovf"}, ovf, e[4]);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] e;
    logic [W-1:0] qa [36];
    logic [W-1:0] qb [36];
    logic exp_done;
    int seen;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", d, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;

    do_op(4'd9,  4'd3,  "a9b3");
    do_op(4'd3,  4'd9,  "a3b9");
    do_op(4'd7,  4'd15, "a7b15");
    do_op(4'd0,  4'd0,  "a0b0");
    do_op(4'd15, 4'd15, "a15b15");
    do_op(4'd0,  4'd15, "a0b15");
    do_op(4'd8,  4'd1,  "a8b1");

    // Result must hold while idle inputs wander.
    e = model(4'd8, 4'd1);
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      check("hold_d", d, e[3:0]);
      check("hold_bout", bout, e[5]);
      check("hold_ovf", ovf, e[4]);
      check("hold_done", done, 0);
    end

    for (int i = 0; i < 20; i++) do_op(W'($urandom), W'($urandom), "rand");

    // Start held high: accepts at cycles 0,6,12,..; done 5 samples later.
    repeat (2) @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 36; i++) begin
      exp_done = (i >= 5) && ((i - 5) % 6 == 0);
      check("b2b_done", done, exp_done);
      if (exp_done) begin
        e = model(qa[i-5], qb[i-5]);
        check("b2b_d", d, e[3:0]);
        check("b2b_bout", bout, e[5]);
        check("b2b_ovf", ovf, e[4]);
      end
      qa[i] = W'($urandom);
      qb[i] = W'($urandom);
      a = qa[i]; b = qb[i];
      @(negedge clk);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset two clocks into SHIFT aborts the operation.
    do_op(4'd9, 4'd3, "pre_abort");
    @(negedge clk);
    a = 4'd5; b = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_d", d, 0);
    check("abort_bout", bout, 0);
    check("abort_ovf", ovf, 0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("abort_no_done", seen, 0);

    // Reset and start on the same edge: reset wins.
    rst = 1'b1; start = 1'b1; a = 4'd12; b = 4'd4;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    @(negedge clk);
    check("rst_start_busy2", busy, 0);
    check("rst_start_done", done, 0);

    for (int i = 0; i < 256; i++) begin
      logic [7:0] p;
      p = 8'(i);
      do_op(p[7:4], p[3:0], "sweep");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
